// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the hazard detection unit: FSM states,
// register-index width, the hard-wired zero register and the default timeout.
package hazard_detection_unit_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hdu_state_t;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the hazard statistics.
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: memory-wait freeze, load-use stall and taken-branch
// flush, with a sticky memory timeout flag and saturating stall/flush statistics.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_uses_Rt,
  input  logic             EX_mem_read,
  input  logic [REG_W-1:0] EX_Rd,
  input  logic             MEM_branch_taken,
  input  logic             MEM_mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             ID_EX_bubble,
  output logic             flush_younger,
  output logic             MEM_WB_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  hdu_state_t        state_reg, state_next;
  logic              branch_pending_reg, branch_pending_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              mem_timeout_reg, mem_timeout_next;

  logic mem_stall, load_use, flush_req, pending_live, stall_evt;

  assign mem_stall = MEM_mem_req & ~mem_ready;
  assign load_use  = EX_mem_read & (EX_Rd != ZERO_REG) &
                     ((EX_Rd == ID_Rs) | ((EX_Rd == ID_Rt) & ID_uses_Rt));
  // A flush parked behind a memory stall is dropped by reset in the same cycle.
  assign pending_live = branch_pending_reg & ~rst;
  assign flush_req    = MEM_branch_taken | pending_live;

  always_comb begin
    pc_write      = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    EX_MEM_write  = 1'b1;
    ID_EX_bubble  = 1'b0;
    flush_younger = 1'b0;
    MEM_WB_bubble = 1'b0;
    if (mem_stall) begin
      pc_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      EX_MEM_write  = 1'b0;
      MEM_WB_bubble = 1'b1;
    end else if (flush_req) begin
      flush_younger = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

  assign stall_evt = MEM_WB_bubble | ID_EX_bubble;

  always_comb begin
    state_next          = state_reg;
    branch_pending_next = mem_stall & (branch_pending_reg | MEM_branch_taken);
    case (state_reg)
      RUN:      if (mem_stall) state_next = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_next = RUN;
      default:  state_next = RUN;
    endcase
    wait_cnt_next = wait_cnt_reg;
    if (state_next == RUN) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg != WAIT_MAX) begin
      wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
    end
    mem_timeout_next = mem_timeout_reg |
                       ((state_next == MEM_WAIT) && (wait_cnt_next == WAIT_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= RUN;
      branch_pending_reg <= 1'b0;
      wait_cnt_reg       <= '0;
      mem_timeout_reg    <= 1'b0;
    end else begin
      state_reg          <= state_next;
      branch_pending_reg <= branch_pending_next;
      wait_cnt_reg       <= wait_cnt_next;
      mem_timeout_reg    <= mem_timeout_next;
    end
  end

  assign mem_timeout = mem_timeout_reg;

  // Index 0 counts stalled cycles, index 1 counts flush cycles.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc = {flush_younger, stall_evt};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stat
      hazard_sat_counter #(
        .W(CNT_W)
      ) u_cnt (
        .clk  (clk),
        .clr  (rst),
        .inc  (cnt_inc[gi]),
        .count(cnt_val[gi])
      );
    end
  endgenerate

  assign stall_cycles = cnt_val[0];
  assign flush_count  = cnt_val[1];

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit; expected control vectors are queued
// when each step is driven and popped when the outputs are sampled.
module tb_hazard_detection_unit;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;

  // {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, ID_EX_bubble, flush_younger, MEM_WB_bubble}
  localparam logic [6:0] V_IDLE = 7'b1111_000;
  localparam logic [6:0] V_LU   = 7'b0011_100;
  localparam logic [6:0] V_MS   = 7'b0000_001;
  localparam logic [6:0] V_FL   = 7'b1111_010;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_Rs, ID_Rt, EX_Rd;
  logic ID_uses_Rt, EX_mem_read, MEM_branch_taken, MEM_mem_req, mem_ready;
  logic pc_write, IF_ID_write, ID_EX_write, EX_MEM_write;
  logic ID_EX_bubble, flush_younger, MEM_WB_bubble, mem_timeout;
  logic [TB_CNT_W-1:0] stall_cycles, flush_count;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  hazard_detection_unit #(
    .TIMEOUT(TB_TIMEOUT),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_Rs           (ID_Rs),
    .ID_Rt           (ID_Rt),
    .ID_uses_Rt      (ID_uses_Rt),
    .EX_mem_read     (EX_mem_read),
    .EX_Rd           (EX_Rd),
    .MEM_branch_taken(MEM_branch_taken),
    .MEM_mem_req     (MEM_mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .IF_ID_write     (IF_ID_write),
    .ID_EX_write     (ID_EX_write),
    .EX_MEM_write    (EX_MEM_write),
    .ID_EX_bubble    (ID_EX_bubble),
    .flush_younger   (flush_younger),
    .MEM_WB_bubble   (MEM_WB_bubble),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check control outputs mid-cycle, then move to
  // just after the rising edge so registered results of this cycle are visible.
  task automatic step(input string tag, input logic r,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic br,
                      input logic req, input logic rdy, input logic [6:0] exp);
    logic [6:0] e;
    string t;
    @(negedge clk);
    rst = r; EX_mem_read = mr; EX_Rd = rd; ID_Rs = rs; ID_Rt = rt;
    ID_uses_Rt = urt; MEM_branch_taken = br; MEM_mem_req = req; mem_ready = rdy;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {25'd0, pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
            ID_EX_bubble, flush_younger, MEM_WB_bubble}, {25'd0, e});
    $display("step %-12s ctl=%b stall=%0d flush=%0d to=%b", t,
             {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write,
              ID_EX_bubble, flush_younger, MEM_WB_bubble},
             stall_cycles, flush_count, mem_timeout);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE);
  endtask

  task automatic do_reset();
    step("reset", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE);
  endtask

  task automatic stats(input string tag, input int s, input int f, input logic to);
    chk({tag, "_stall"}, 32'(stall_cycles), 32'(s));
    chk({tag, "_flush"}, 32'(flush_count), 32'(f));
    chk({tag, "_tmo"}, {31'd0, mem_timeout}, {31'd0, to});
  endtask

  initial begin
    rst = 1'b1; ID_Rs = '0; ID_Rt = '0; EX_Rd = '0; ID_uses_Rt = 1'b0;
    EX_mem_read = 1'b0; MEM_branch_taken = 1'b0; MEM_mem_req = 1'b0; mem_ready = 1'b0;

    do_reset();
    stats("rst", 0, 0, 1'b0);

    // Load-use on Rs, then the load moves on.
    step("lu_rs", 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, V_LU);
    stats("lu_rs", 1, 0, 1'b0);
    idle("lu_after");
    stats("lu_after", 1, 0, 1'b0);

    step("zero_reg", 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, V_IDLE);
    step("rt_gated", 0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0, V_IDLE);
    step("rt_used", 0, 1, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0, V_LU);
    step("no_load", 0, 0, 5'd8, 5'd8, 5'd8, 1, 0, 0, 0, V_IDLE);
    stats("rt", 2, 0, 1'b0);

    // Memory wait of 3 cycles.
    do_reset();
    for (int i = 0; i < 3; i++)
      step("mwait", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MS);
    step("mready", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, V_IDLE);
    stats("mwait", 3, 0, 1'b0);

    // Branch during wait is deferred until the access completes.
    do_reset();
    step("br_wait1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, V_MS);
    step("br_wait2", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MS);
    step("br_wait3", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MS);
    step("br_ready", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, V_FL);
    idle("br_after");
    stats("br_wait", 3, 1, 1'b0);

    // Branch beats load-use; branch with completing access flushes at once.
    step("br_lu", 0, 1, 5'd9, 5'd9, 5'd0, 0, 1, 0, 0, V_FL);
    step("br_rdy", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, V_FL);
    step("all_hz", 0, 1, 5'd9, 5'd9, 5'd0, 0, 1, 1, 0, V_MS);
    step("all_done", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, V_FL);
    stats("br_mix", 4, 4, 1'b0);

    // Wait counter restarts in RUN: two 3-cycle waits never time out.
    do_reset();
    for (int i = 0; i < 3; i++)
      step("w3a", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MS);
    step("w3a_rdy", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, V_IDLE);
    for (int i = 0; i < 3; i++)
      step("w3b", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MS);
    stats("w3b", 6, 0, 1'b0);

    // Timeout after the 4th wait cycle, sticky until reset.
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step("tmo_wait", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MS);
      chk($sformatf("tmo_c%0d", i), {31'd0, mem_timeout}, {31'd0, (i >= 4)});
    end
    step("tmo_rdy", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, V_IDLE);
    idle("tmo_idle");
    stats("tmo_hold", 6, 0, 1'b1);
    do_reset();
    stats("tmo_clr", 0, 0, 1'b0);

    // Reset mid-wait discards a pending flush.
    step("rp_wait", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, V_MS);
    do_reset();
    idle("rp_after");
    stats("rp", 0, 0, 1'b0);

    // Saturation of both statistics counters.
    for (int i = 0; i < 18; i++)
      step("sat_stall", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, V_MS);
    step("sat_rdy", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, V_IDLE);
    for (int i = 0; i < 18; i++)
      step("sat_flush", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, V_FL);
    stats("sat", 15, 15, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
